// File: rtl/macc_dsp_pipe_if.sv
// Beat-in / result-out bundle for macc_dsp_pipe.
// The master side produces operand beats and consumes results.
interface macc_dsp_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [24:0] in_b;
    logic        in_load;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_p;
    logic        out_ovf;
    logic        out_last;

    modport master (
        output in_valid, in_a, in_b, in_load, in_last, out_ready,
        input  in_ready, out_valid, out_p, out_ovf, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_load, in_last, out_ready,
        output in_ready, out_valid, out_p, out_ovf, out_last
    );
endinterface

// File: rtl/macc_dsp_pipe.sv
// Three-stage unsigned 18x25 multiply with 48-bit accumulate.
// Stage 1 registers operands, stage 2 the product, stage 3 the accumulator.
// A single advance enable freezes every stage while a result is refused.
module macc_dsp_pipe #(
    parameter int LATENCY = 3
) (
    input logic           clk,
    input logic           rst,
    macc_dsp_pipe_if.slave bus
);
    localparam int DATA_W = 18;
    localparam int COEF_W = 25;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 48;

    // The pipeline depth is structural; LATENCY only documents it.
    if (LATENCY != 3) begin : g_latency_check
        $error("macc_dsp_pipe: LATENCY is fixed at 3");
    end

    // Full-width add that exposes the carry out of the accumulator.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] addend);
        return {1'b0, acc} + {1'b0, addend};
    endfunction

    // Stage 1: operand registers
    logic              v_p1_q,    v_p1_d;
    logic [DATA_W-1:0] a_p1_q,    a_p1_d;
    logic [COEF_W-1:0] b_p1_q,    b_p1_d;
    logic              load_p1_q, load_p1_d;
    logic              last_p1_q, last_p1_d;
    // Stage 2: product registers
    logic              v_p2_q,    v_p2_d;
    logic [ACC_W-1:0]  m_p2_q,    m_p2_d;
    logic              load_p2_q, load_p2_d;
    logic              last_p2_q, last_p2_d;
    // Stage 3: accumulator and result flags
    logic              v_p3_q,    v_p3_d;
    logic [ACC_W-1:0]  p_p3_q,    p_p3_d;
    logic              ovf_p3_q,  ovf_p3_d;
    logic              last_p3_q, last_p3_d;

    logic              ce;
    logic [PROD_W-1:0] prod_p1;
    logic [ACC_W:0]    sum_p2;

    // A held result stalls everything; an empty output slot never blocks.
    assign ce           = !v_p3_q || bus.out_ready;
    assign bus.in_ready = ce;

    assign prod_p1 = PROD_W'(a_p1_q) * PROD_W'(b_p1_q);
    assign sum_p2  = acc_add(p_p3_q, m_p2_q);

    assign bus.out_valid = v_p3_q;
    assign bus.out_p     = p_p3_q;
    assign bus.out_ovf   = ovf_p3_q;
    assign bus.out_last  = last_p3_q;

    // Next-state for all stages; every register holds unless ce advances it.
    always_comb begin
        v_p1_d    = v_p1_q;
        a_p1_d    = a_p1_q;
        b_p1_d    = b_p1_q;
        load_p1_d = load_p1_q;
        last_p1_d = last_p1_q;
        v_p2_d    = v_p2_q;
        m_p2_d    = m_p2_q;
        load_p2_d = load_p2_q;
        last_p2_d = last_p2_q;
        v_p3_d    = v_p3_q;
        p_p3_d    = p_p3_q;
        ovf_p3_d  = ovf_p3_q;
        last_p3_d = last_p3_q;
        if (ce) begin
            // p0 -> p1: operands are captured even on bubbles
            v_p1_d    = bus.in_valid;
            a_p1_d    = bus.in_a;
            b_p1_d    = bus.in_b;
            load_p1_d = bus.in_load;
            last_p1_d = bus.in_last;
            // p1 -> p2: product, zero-extended to accumulator width
            v_p2_d    = v_p1_q;
            m_p2_d    = {{(ACC_W-PROD_W){1'b0}}, prod_p1};
            load_p2_d = load_p1_q;
            last_p2_d = last_p1_q;
            // p2 -> p3: only valid beats touch the accumulator
            v_p3_d    = v_p2_q;
            if (v_p2_q) begin
                if (load_p2_q) begin
                    p_p3_d   = m_p2_q;
                    ovf_p3_d = 1'b0;
                end else begin
                    p_p3_d   = sum_p2[ACC_W-1:0];
                    ovf_p3_d = ovf_p3_q | sum_p2[ACC_W];
                end
                last_p3_d = last_p2_q;
            end
        end
    end

    // Valid pipeline and architecturally visible result state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_p1_q    <= 1'b0;
            v_p2_q    <= 1'b0;
            v_p3_q    <= 1'b0;
            p_p3_q    <= '0;
            ovf_p3_q  <= 1'b0;
            last_p3_q <= 1'b0;
        end else begin
            v_p1_q    <= v_p1_d;
            v_p2_q    <= v_p2_d;
            v_p3_q    <= v_p3_d;
            p_p3_q    <= p_p3_d;
            ovf_p3_q  <= ovf_p3_d;
            last_p3_q <= last_p3_d;
        end
    end

    // Datapath carried alongside the valids; qualified by them, so no reset.
    always_ff @(posedge clk) begin
        a_p1_q    <= a_p1_d;
        b_p1_q    <= b_p1_d;
        load_p1_q <= load_p1_d;
        last_p1_q <= last_p1_d;
        m_p2_q    <= m_p2_d;
        load_p2_q <= load_p2_d;
        last_p2_q <= last_p2_d;
    end
endmodule

// File: tb/tb_macc_dsp_pipe.sv
// Scoreboard bench for macc_dsp_pipe: directed beats push their expected
// results; an independent monitor pops and compares each accepted output.
module tb_macc_dsp_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    macc_dsp_pipe_if bus ();

    macc_dsp_pipe #(.LATENCY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [47:0] p;
        logic        ovf;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [47:0] MAXPROD = 48'h7FFFDFC0001;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, optionally expect a result.
    task automatic send(input logic [17:0] a, input logic [24:0] b, input logic ld,
                        input logic lst, input logic [47:0] ep, input logic eovf,
                        input bit expect_out);
        int   waitc;
        exp_t e;
        waitc        = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_load  = ld;
        bus.in_last  = lst;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready) begin
            waitc++;
            if (waitc > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        if (expect_out) begin
            e.p    = ep;
            e.ovf  = eovf;
            e.last = lst;
            exp_q.push_back(e);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been retired.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transferred output is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=0x%0h required=no_output", bus.out_p);
                end else begin
                    e = exp_q.pop_front();
                    check("out_p", 64'(bus.out_p), 64'(e.p));
                    check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                    check("out_last", 64'(bus.out_last), 64'(e.last));
                end
            end
        end
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [48:0] s;
        logic [47:0] mp;
        logic        mo;
        int          nv;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_load   = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_p", 64'(bus.out_p), 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single load beat: result visible after the third edge counting the capture edge
        send(18'd3, 25'd5, 1'b1, 1'b0, 48'd15, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge2_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge3_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        check("post_take_valid", 64'(bus.out_valid), 64'd0);
        check("post_take_p", 64'(bus.out_p), 64'd15);
        @(posedge clk);
        #1;

        // Back-to-back load/acc with one bubble before the last beat
        send(18'd2, 25'd7, 1'b1, 1'b0, 48'd14, 1'b0, 1'b1);
        send(18'd4, 25'd10, 1'b0, 1'b0, 48'd54, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        send(18'd1, 25'd1, 1'b0, 1'b1, 48'd55, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("bubble_valid", 64'(bus.out_valid), 64'd0);
        check("bubble_p", 64'(bus.out_p), 64'd54);
        drain();

        // Maximum operands, accumulated until the 48-bit sum wraps (beat 33)
        send(18'h3FFFF, 25'h1FFFFFF, 1'b1, 1'b0, MAXPROD, 1'b0, 1'b1);
        mp = MAXPROD;
        mo = 1'b0;
        for (int k = 2; k <= 34; k++) begin
            s  = {1'b0, mp} + {1'b0, MAXPROD};
            mp = s[47:0];
            mo = mo | s[48];
            send(18'h3FFFF, 25'h1FFFFFF, 1'b0, 1'b0, mp, mo, 1'b1);
        end
        send(18'd1, 25'd1, 1'b1, 1'b0, 48'd1, 1'b0, 1'b1);
        drain();

        // Backpressure: load 0 then six +1 beats, consumer refuses for 4 cycles
        fork
            begin
                send(18'd0, 25'd0, 1'b1, 1'b0, 48'd0, 1'b0, 1'b1);
                for (int k = 1; k <= 6; k++)
                    send(18'd1, 25'd1, 1'b0, 1'b0, 48'(k), 1'b0, 1'b1);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!(bus.in_valid && bus.in_ready) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_out_p", 64'(bus.out_p), 64'd0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                nv = 0;
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) nv++;
                end
                check("stream_no_gaps", 64'(nv), 64'd7);
            end
        join
        drain();

        // Reset mid-stream drops in-flight beats and clears the accumulator
        send(18'd10, 25'd10, 1'b1, 1'b0, 48'd100, 1'b0, 1'b1);
        drain();
        send(18'd5, 25'd5, 1'b1, 1'b0, 48'd0, 1'b0, 1'b0);
        send(18'd6, 25'd6, 1'b0, 1'b0, 48'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check("dropped_valids", 64'(nv), 64'd0);
        check("rst_clears_p", 64'(bus.out_p), 64'd0);
        @(posedge clk);
        #1;
        send(18'd2, 25'd3, 1'b0, 1'b0, 48'd6, 1'b0, 1'b1);
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
